// File: rtl/mux_serializer_ctrl_if.sv
// Handshake and mux-side bus of the 8:1 parallel-to-serial front end.
// master = upstream/word source side, slave = the serializer itself.
interface mux_serializer_ctrl_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] data_q;
    logic [2:0] sel;
    logic       sout;
    logic       sout_valid;
    logic       sout_first;
    logic       sout_last;
    logic       busy;

    modport master (
        output din, din_valid,
        input  din_ready, data_q, sel, sout, sout_valid, sout_first, sout_last, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, data_q, sel, sout, sout_valid, sout_first, sout_last, busy
    );
endinterface

// File: rtl/mux_serializer_ctrl.sv
// Parallel-to-serial front end for the 8:1 mux: holds a word on data_q and steps sel 0..7.
// Optional even-parity cycle after bit 7 when SERIALIZER_PARITY_EN is defined.
module mux_serializer_ctrl #(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_serializer_ctrl_if.slave  ser
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam bit         BACK_TO_BACK = (GAP_CYCLES == 0);
    localparam state_t     ST_DONE      = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
    localparam logic [3:0] GAP_LOAD     = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] data_r;
    logic [2:0] sel_r;
    logic [3:0] gap_cnt;
    logic       last_cycle;
    logic       ready;
    logic       accept;
    logic       shifting;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Shared decode: ready during the last serial cycle enables a bubble-free reload.
    always_comb begin
`ifdef SERIALIZER_PARITY_EN
        last_cycle = (state == ST_PAR);
`else
        last_cycle = (state == ST_SHIFT) && (sel_r == 3'd7);
`endif
        ready  = !rst && ((state == ST_IDLE) || (BACK_TO_BACK && last_cycle));
        accept = ser.din_valid && ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (sel_r == 3'd7) begin
`ifdef SERIALIZER_PARITY_EN
                    state_nxt = ST_PAR;
`else
                    state_nxt = accept ? ST_SHIFT : ST_DONE;
`endif
                end
            end
            ST_PAR:   state_nxt = accept ? ST_SHIFT : ST_DONE;
            ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // sel only wraps through a load; it parks at 7 until the next word.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= '0;
            sel_r   <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) begin
                data_r <= ser.din;
                sel_r  <= '0;
            end else if ((state == ST_SHIFT) && (sel_r != 3'd7)) begin
                sel_r <= sel_r + 3'd1;
            end

            if (state != ST_GAP)     gap_cnt <= GAP_LOAD;
            else if (gap_cnt != '0)  gap_cnt <= gap_cnt - 4'd1;
        end
    end

    always_comb begin
        shifting       = !rst && ((state == ST_SHIFT) || (state == ST_PAR));
        ser.din_ready  = ready;
        ser.sout_valid = shifting;
        ser.sout_first = !rst && (state == ST_SHIFT) && (sel_r == 3'd0);
        ser.sout_last  = !rst && last_cycle;
        ser.busy       = !rst && (state != ST_IDLE);
        ser.sout       = 1'b0;
        if (shifting) ser.sout = (state == ST_PAR) ? ^data_r : data_r[sel_r];
    end

    assign ser.data_q = data_r;
    assign ser.sel    = sel_r;
endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// Bench for mux_serializer_ctrl: GAP_CYCLES=0 and GAP_CYCLES=3 instances share one stimulus
// stream and are each checked against a per-cycle schedule model.
module tb_mux_serializer_ctrl;
`ifdef SERIALIZER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic       valid;
        logic       bit_v;
        logic       first;
        logic       last;
        logic       busy;
        logic [2:0] sel;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_serializer_ctrl_if bus0 ();
    mux_serializer_ctrl_if bus3 ();

    mux_serializer_ctrl #(.GAP_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .ser(bus0));
    mux_serializer_ctrl #(.GAP_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .ser(bus3));

    int unsigned gap_cfg [2] = '{0, 3};
    rec_t        mq [2][$];
    logic [7:0]  m_dq [2];
    logic [2:0]  m_idle_sel [2];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic rec_t mk(input logic v, input logic b, input logic f, input logic l,
                                input logic bz, input logic [2:0] s);
        rec_t r;
        r.valid = v; r.bit_v = b; r.first = f; r.last = l; r.busy = bz; r.sel = s;
        return r;
    endfunction

    // Expected behaviour of one cycle: head of the schedule, or idle when the schedule is empty.
    task automatic check_inst(input int i, input logic r, input logic rdy, input logic [7:0] dq,
                              input logic [2:0] sl, input logic so, input logic sv,
                              input logic sf, input logic sla, input logic bz);
        rec_t  e;
        logic  e_rdy;
        string p;
        p = $sformatf("gap%0d.", gap_cfg[i]);
        if (r) begin
            e = '0;
            e_rdy = 1'b0;
        end else if (mq[i].size() > 0) begin
            e = mq[i][0];
            e_rdy = e.last && (gap_cfg[i] == 0);
        end else begin
            e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_idle_sel[i]);
            e_rdy = 1'b1;
        end
        check({p, "din_ready"},  {7'd0, rdy}, {7'd0, e_rdy});
        check({p, "sout_valid"}, {7'd0, sv},  {7'd0, e.valid});
        check({p, "sout"},       {7'd0, so},  {7'd0, e.bit_v});
        check({p, "sout_first"}, {7'd0, sf},  {7'd0, e.first});
        check({p, "sout_last"},  {7'd0, sla}, {7'd0, e.last});
        check({p, "busy"},       {7'd0, bz},  {7'd0, e.busy});
        if (!r) begin
            check({p, "data_q"}, dq, m_dq[i]);
            check({p, "sel"}, {5'd0, sl}, {5'd0, e.sel});
        end
    endtask

    task automatic model_step(input int i, input logic r, input logic v, input logic [7:0] d);
        logic rdy;
        if (r) begin
            mq[i].delete();
            m_dq[i] = '0;
            m_idle_sel[i] = '0;
        end else begin
            rdy = (mq[i].size() == 0) || (mq[i][0].last && (gap_cfg[i] == 0));
            if (mq[i].size() > 0) begin
                m_idle_sel[i] = mq[i][0].sel;
                void'(mq[i].pop_front());
            end
            if (v && rdy) begin
                m_dq[i] = d;
                for (int k = 0; k < 8; k++)
                    mq[i].push_back(mk(1'b1, d[k], k == 0, (k == 7) && !PAR_EN, 1'b1, 3'(k)));
                if (PAR_EN)
                    mq[i].push_back(mk(1'b1, ^d, 1'b0, 1'b1, 1'b1, 3'd7));
                for (int g = 0; g < int'(gap_cfg[i]); g++)
                    mq[i].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7));
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d);
        rst = r;
        bus0.din_valid = v; bus0.din = d;
        bus3.din_valid = v; bus3.din = d;
        #1;
        check_inst(0, r, bus0.din_ready, bus0.data_q, bus0.sel, bus0.sout, bus0.sout_valid,
                   bus0.sout_first, bus0.sout_last, bus0.busy);
        check_inst(1, r, bus3.din_ready, bus3.data_q, bus3.sel, bus3.sout, bus3.sout_valid,
                   bus3.sout_first, bus3.sout_last, bus3.busy);
        for (int i = 0; i < 2; i++) model_step(i, r, v, d);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic       r;
        logic       v;
        logic [7:0] d;
        bus0.din_valid = 1'b0; bus0.din = '0;
        bus3.din_valid = 1'b0; bus3.din = '0;
        for (int i = 0; i < 2; i++) begin
            m_dq[i] = '0;
            m_idle_sel[i] = '0;
        end
        @(negedge clk);

        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);

        cycle(1'b0, 1'b1, 8'hE5);
        repeat (12) cycle(1'b0, 1'b0, 8'h00);

        // A5 then 3C held: the gap-free instance takes 3C on A5's last cycle.
        cycle(1'b0, 1'b1, 8'hA5);
        repeat (8) cycle(1'b0, 1'b1, 8'h3C);
        repeat (16) cycle(1'b0, 1'b0, 8'h00);

        cycle(1'b0, 1'b1, 8'hE1);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h55);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h55);
        repeat (12) cycle(1'b0, 1'b0, 8'h00);

        // Reset lands on bit 4 of 8'hFF.
        cycle(1'b0, 1'b1, 8'hFF);
        repeat (4) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h01);
        repeat (12) cycle(1'b0, 1'b0, 8'h00);

        cycle(1'b0, 1'b1, 8'h00);
        repeat (12) cycle(1'b0, 1'b0, 8'h00);

        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            cycle(r, v, d);
        end
        repeat (15) cycle(1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
